// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: a DEPTH-entry {pc, instr} FIFO with flush and back-pressure.
// Optional FETCHQ_STATS_EN adds a saturating counter of entries discarded by flushes.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   instr_in,
  input  logic          fetch_valid,
  output logic          fetch_ready,
  input  logic          flush,
  input  logic          ifid_write,
  output logic          valid_id,
  output logic [31:0]   pc_id,
  output logic [31:0]   pc_plus4_id,
  output logic [31:0]   instr_id,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [15:0]   flush_count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  // Ready depends only on registered occupancy, so a full queue refuses a push even when popping.
  assign fetch_ready = (count_q != CW'(DEPTH));
  assign valid_id    = (count_q != '0);
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign pop         = ifid_write & valid_id & ~flush;

  assign pc_id       = valid_id ? pc_mem_q[rd_ptr_q]    : 32'h0;
  assign instr_id    = valid_id ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc_plus4_id = pc_id + 32'd4;
  assign count       = count_q;
  assign overflow    = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (fetch_valid && !fetch_ready) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is never reset; it is only visible through valid_id gating.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem_q[wr_ptr_q]    <= pc_in;
      instr_mem_q[wr_ptr_q] <= instr_in;
    end
  end

`ifdef FETCHQ_STATS_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [16:0] flush_sum;

  assign flush_sum   = {1'b0, flush_cnt_q} + 17'(count_q);
  assign flush_count = flush_cnt_q;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush) flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flush_cnt_q <= '0;
    else       flush_cnt_q <= flush_cnt_d;
  end
`else
  assign flush_count = 16'h0000;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the PC/instruction-memory fetch stage and the ID stage. It replaces the bare IF/ID register.
- Buffers {PC, instruction} pairs so fetch can run ahead of a stalled decode.
- Applies pipeline back-pressure through `fetch_ready`, which drives the PC write enable.
- Discards all buffered instructions on a taken branch from EX/MEM.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, minimum 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc_in  input  32  PC of the instruction being fetched this cycle.
- instr_in  input  32  instruction word from instruction memory for `pc_in`.
- fetch_valid  input  1  `pc_in`/`instr_in` are valid this cycle (push request).
- fetch_ready  output  1  queue can accept a push; drives the PC stage `pcwrite`.
- flush  input  1  taken branch or jump resolved downstream (zero_flag_ex_mem & branch_ex_mem, or jump); discards the queue.
- ifid_write  input  1  decode consumes the head entry this cycle (pop request); 0 means hazard stall.
- valid_id  output  1  head entry present.
- pc_id  output  32  PC of the head entry.
- pc_plus4_id  output  32  pc_id + 4, modulo 2^32.
- instr_id  output  32  instruction of the head entry.
- count  output  CW  current occupancy, 0..DEPTH.
- overflow  output  1  sticky error flag: push attempted while full.
- flush_count  output  16  discarded-entry statistics; see Optional Feature.

Behaviour:
- **Storage.** Circular buffer of DEPTH entries, each {pc[31:0], instr[31:0]}. Read and write pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- **Push/pop conditions.**
  - push = fetch_valid & fetch_ready & ~flush.
  - pop = ifid_write & valid_id & ~flush.
- **fetch_ready** = (count != DEPTH). It is a pure function of registered count, with no combinational path from `ifid_write`. A full queue with a simultaneous pop still refuses the push.
- **Head outputs.** Combinational reads of the registered head entry.
  - When count == 0: valid_id = 0, pc_id = 0, pc_plus4_id = 4, instr_id = 32'h0000_0000 (NOP).
  - A pushed entry appears on the outputs the cycle after the push edge, so IF→ID latency is 1 cycle, the same as a plain register.
- **Count update.**
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. Both pointers advance and order is preserved (FIFO).
- **Flush.**
  - At the next edge: count ← 0, read pointer ← write pointer, and valid_id is 0 from that cycle.
  - Flush takes priority over push and pop; any same-cycle push is dropped. The PC stage loads the branch target in that same cycle, so the next push is the target instruction.
- **Stall.** While ifid_write = 0 the head entry and all outputs hold. Pushes continue until the queue is full, then fetch_ready = 0 freezes the PC.
- **Overflow.**
  - fetch_valid & ~fetch_ready & ~flush sets `overflow` (sticky). The entry is dropped and the state is unchanged.
  - Only reset clears `overflow`.
- **Reset.**
  - At the edge with reset = 1: pointers = 0, count = 0, overflow = 0, flush_count = 0.
  - Outputs then take their empty values: valid_id = 0, instr_id = 0, pc_id = 0, pc_plus4_id = 4, fetch_ready = 1.
  - Reset overrides flush, push and pop. Reset asserted mid-stall or with a full queue empties the queue identically.
  - Entry contents are not cleared and are never observable while invalid.

Optional Feature:
- Macro: FETCHQ_STATS_EN.
- **Defined:** `flush_count` is a 16-bit saturating counter.
  - On each flush it adds the number of valid entries discarded (count before flush).
  - It saturates at 16'hFFFF and clears on reset.
- **Undefined:** `flush_count` is tied to 16'h0000 and no counter logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset, then push PC 0x00, 0x04, 0x08 with ifid_write = 1 every cycle → valid_id rises 1 cycle after the first push; pc_id sequence 0x00, 0x04, 0x08 on consecutive cycles; count stays at 1 or below; pc_plus4_id = pc_id + 4.
- Hold ifid_write = 0, push continuously (DEPTH = 4) → count reaches 4; fetch_ready = 0 on the cycle after the 4th push; head stays PC 0x00; overflow = 0.
- Full queue, release ifid_write = 1 for 1 cycle while fetch_valid = 1 → exactly one pop and no push that cycle; count = 3; fetch_ready = 1 next cycle; head = 0x04.
- Three entries queued, assert flush with fetch_valid = 1 (PC 0x40) → next cycle count = 0, valid_id = 0, instr_id = 0; PC 0x40 is not enqueued. With FETCHQ_STATS_EN, flush_count = 3.
- Force fetch_valid = 1 while full (PC stage ignoring fetch_ready) → overflow = 1 and stays 1 until reset; queue contents and order unchanged.
- Assert reset with 2 entries queued and ifid_write = 0 → next cycle count = 0, valid_id = 0, fetch_ready = 1, overflow = 0, flush_count = 0.
